wb_register_file: RTL



---
 rtl/wb_register_file_if.sv | 41 ++++
 rtl/wb_register_file.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wb_register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_register_file_if
// Description : Wishbone classic bus bundle between an initiator and the
//               wb_register_file responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_register_file_if #(
    parameter int WB_ADR_BITS = 38,
    parameter int WB_DAT_BITS = 32,
    parameter int WB_SEL_BITS = WB_DAT_BITS / 8
);
    logic [WB_ADR_BITS-1:0] s_wb_adr_i;
    logic [WB_DAT_BITS-1:0] s_wb_dat_o;
    logic [WB_DAT_BITS-1:0] s_wb_dat_i;
    logic [WB_SEL_BITS-1:0] s_wb_sel_i;
    logic                   s_wb_we_i;
    logic                   s_wb_stb_i;
    logic                   s_wb_ack_o;

    modport master (
        output s_wb_adr_i,
        output s_wb_dat_i,
        output s_wb_sel_i,
        output s_wb_we_i,
        output s_wb_stb_i,
        input  s_wb_dat_o,
        input  s_wb_ack_o
    );

    modport slave (
        input  s_wb_adr_i,
        input  s_wb_dat_i,
        input  s_wb_sel_i,
        input  s_wb_we_i,
        input  s_wb_stb_i,
        output s_wb_dat_o,
        output s_wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : wb_register_file
// Description : Wishbone classic responder holding REG_NUM byte-lane writable
//               registers, a read-only core ID and a wrapping write counter.
//               One registered ack per stb assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_register_file #(
    parameter int                     WB_ADR_BITS = 38,
    parameter int                     WB_DAT_BITS = 32,
    parameter int                     WB_SEL_BITS = WB_DAT_BITS / 8,
    parameter int                     REG_NUM     = 4,
    parameter logic [WB_DAT_BITS-1:0] INIT_VALUE  = '0,
    parameter logic [WB_DAT_BITS-1:0] CORE_ID     = 32'h5a5a_0001
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    wb_register_file_if.slave                   s_wb,
    output logic [REG_NUM*WB_DAT_BITS-1:0]      out_regs
);

    localparam int                     c_IDX_BITS = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [WB_ADR_BITS-1:0] c_ADR_ID   = WB_ADR_BITS'(REG_NUM);
    localparam logic [WB_ADR_BITS-1:0] c_ADR_CNT  = WB_ADR_BITS'(REG_NUM + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACK  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_rw_hit;
    logic [c_IDX_BITS-1:0]  w_idx;
    logic [WB_DAT_BITS-1:0] w_rd_data;
    logic                   r_ack;
    logic [WB_DAT_BITS-1:0] r_dat_o;
    logic [WB_DAT_BITS-1:0] r_wcnt;
    logic [WB_DAT_BITS-1:0] r_regs [REG_NUM];

    // State register: protocol position of the current stb assertion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept in IDLE, then hold off until stb has been seen low
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (s_wb.s_wb_stb_i)  w_state_nxt = c_ST_ACK;
            c_ST_ACK:  w_state_nxt = s_wb.s_wb_stb_i ? c_ST_WAIT : c_ST_IDLE;
            c_ST_WAIT: if (!s_wb.s_wb_stb_i) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode: a transaction is accepted only from IDLE with stb high
    always_comb begin
        w_accept = (r_state == c_ST_IDLE) && s_wb.s_wb_stb_i;
        w_rw_hit = (s_wb.s_wb_adr_i < c_ADR_ID);
        w_wr_en  = w_accept && s_wb.s_wb_we_i && w_rw_hit;
        w_idx    = s_wb.s_wb_adr_i[c_IDX_BITS-1:0];
    end

    // Read mux over the address map; unmapped words read as zero
    always_comb begin
        w_rd_data = '0;
        if (w_rw_hit) begin
            w_rd_data = r_regs[w_idx];
        end else if (s_wb.s_wb_adr_i == c_ADR_ID) begin
            w_rd_data = CORE_ID;
        end else if (s_wb.s_wb_adr_i == c_ADR_CNT) begin
            w_rd_data = r_wcnt;
        end
    end

    // Register array: byte-lane masked update on accepted RW writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                r_regs[r] <= INIT_VALUE;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < WB_SEL_BITS; i++) begin
                if (s_wb.s_wb_sel_i[i]) begin
                    r_regs[w_idx][8*i +: 8] <= s_wb.s_wb_dat_i[8*i +: 8];
                end
            end
        end
    end

    // Write counter: every accepted write counts, whatever its address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt <= '0;
        end else if (w_accept && s_wb.s_wb_we_i) begin
            r_wcnt <= r_wcnt + WB_DAT_BITS'(1);
        end
    end

    // Ack and read data: both live only for the single ACK cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_accept;
            r_dat_o <= (w_accept && !s_wb.s_wb_we_i) ? w_rd_data : '0;
        end
    end

    assign s_wb.s_wb_ack_o = r_ack;
    assign s_wb.s_wb_dat_o = r_dat_o;

    generate
        for (genvar g = 0; g < REG_NUM; g++) begin : g_out
            assign out_regs[g*WB_DAT_BITS +: WB_DAT_BITS] = r_regs[g];
        end
    endgenerate

endmodule
`default_nettype wire
